// File: rtl/cpu_pkg.sv
// Types and constants shared by the fetch and decode stages.
package cpu_pkg;
  typedef logic [31:0] instr_t;

  localparam instr_t      NOP_INSTR        = 32'h0;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef struct packed {
    instr_t      data;
    logic [31:0] pc;
  } fetch_word_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h3;
  endfunction
endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: decode-side control, instruction memory port and the IF/ID output.
interface instr_fetch_if #(parameter int ADDR_W = 8);
  import cpu_pkg::*;

  logic              stall;
  logic              redirect_valid;
  logic [31:0]       redirect_target;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  instr_t            imem_rdata;
  instr_t            dataout;
  logic [31:0]       pc_out;
  logic              valid;

  modport master (
    input  stall, redirect_valid, redirect_target, imem_rdata,
    output imem_en, imem_addr, dataout, pc_out, valid
  );

  modport slave (
    output stall, redirect_valid, redirect_target, imem_rdata,
    input  imem_en, imem_addr, dataout, pc_out, valid
  );
endinterface

// File: rtl/fetch_skid.sv
// Single-entry {data, pc} holding register; clear wins over load.
module fetch_skid
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  fetch_word_t din,
  output logic        valid,
  output fetch_word_t dout
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, synchronous imem request, skid-buffered output toward IF/ID.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  instr_fetch_if.master bus
);

  logic [31:0] fetch_pc;
  logic [31:0] inflight_pc;
  logic        inflight;
  logic        skid_valid;
  logic        skid_load;
  logic        skid_clear;
  fetch_word_t skid_in;
  fetch_word_t skid_word;

  // Requests stop while stalled, so at most one word can land in the skid.
  assign bus.imem_en   = !reset && !bus.stall && !bus.redirect_valid;
  assign bus.imem_addr = fetch_pc[ADDR_W+1:2];

  assign skid_in    = '{data: bus.imem_rdata, pc: inflight_pc};
  assign skid_load  = bus.stall && inflight && !bus.redirect_valid;
  assign skid_clear = bus.redirect_valid || (!bus.stall && skid_valid);

  fetch_skid u_skid (
    .clock (clock),
    .reset (reset),
    .load  (skid_load),
    .clear (skid_clear),
    .din   (skid_in),
    .valid (skid_valid),
    .dout  (skid_word)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      bus.dataout <= NOP_INSTR;
      bus.pc_out  <= '0;
      bus.valid   <= 1'b0;
    end else if (bus.redirect_valid) begin
      fetch_pc    <= align_pc(bus.redirect_target);
      inflight    <= 1'b0;
      bus.dataout <= NOP_INSTR;
      bus.pc_out  <= '0;
      bus.valid   <= 1'b0;
    end else if (bus.stall) begin
      inflight <= 1'b0;
    end else begin
      fetch_pc    <= fetch_pc + PC_STEP;
      inflight    <= 1'b1;
      inflight_pc <= fetch_pc;
      if (skid_valid) begin
        bus.dataout <= skid_word.data;
        bus.pc_out  <= skid_word.pc;
        bus.valid   <= 1'b1;
      end else if (inflight) begin
        bus.dataout <= bus.imem_rdata;
        bus.pc_out  <= inflight_pc;
        bus.valid   <= 1'b1;
      end else begin
        bus.dataout <= NOP_INSTR;
        bus.pc_out  <= '0;
        bus.valid   <= 1'b0;
      end
    end
  end

endmodule
